restoring_divider_16b: RTL and testbench

Iterative restoring divider for the arithmetic accelerator, the inverse operation to the adder/multiplier datapaths. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one trial subtraction per clock. A start/done handshake lets the accelerator issue a division and collect the result without stalling the other arithmetic units.

---
 rtl/restoring_divider_16b.sv | 102 ++++++++++
 tb/tb_restoring_divider_16b.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_16b.sv
// restoring_divider_16b: iterative restoring divider, one trial subtraction per clock; define DIVIDER_SIGNED_EN for two's-complement operands
module restoring_divider_16b #(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivByZero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q, quo_q, rmo_q;
  logic             zero_q, dbz_q, done_q;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] trial, rem_d, dvd_d, a_mag, b_mag, rsrc, fix_q, fix_r;
`ifdef DIVIDER_SIGNED_EN
  logic             qneg_q, rneg_q;
`endif
  // One restoring step, operand magnitudes at capture and result sign fix-up
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    take    = shifted >= {1'b0, dsr_q};
    trial   = shifted[WIDTH-1:0] - dsr_q;
    rem_d   = take ? trial : shifted[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], take};
    rsrc    = zero_q ? dvd_q : rem_q;
`ifdef DIVIDER_SIGNED_EN
    a_mag   = iDividend[WIDTH-1] ? -iDividend : iDividend;
    b_mag   = iDivisor[WIDTH-1] ? -iDivisor : iDivisor;
    fix_q   = zero_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
    fix_r   = rneg_q ? -rsrc : rsrc;
`else
    a_mag   = iDividend;
    b_mag   = iDivisor;
    fix_q   = zero_q ? '1 : dvd_q;
    fix_r   = rsrc;
`endif
  end
  // Control FSM: capture on start, iterate WIDTH times, publish results with a done pulse
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmo_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (iStart) begin
          dvd_q   <= a_mag;
          dsr_q   <= b_mag;
          rem_q   <= '0;
          cnt_q   <= '0;
          zero_q  <= iDivisor == '0;
`ifdef DIVIDER_SIGNED_EN
          qneg_q  <= iDividend[WIDTH-1] ^ iDivisor[WIDTH-1];
          rneg_q  <= iDividend[WIDTH-1];
`endif
          state_q <= (iDivisor == '0) ? FIX : RUN;
        end
        RUN: begin
          rem_q   <= rem_d;
          dvd_q   <= dvd_d;
          cnt_q   <= cnt_q + CW'(1);
          state_q <= (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
        end
        FIX: begin
          quo_q   <= fix_q;
          rmo_q   <= fix_r;
          dbz_q   <= zero_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign oQuotient  = quo_q;
  assign oRemainder = rmo_q;
  assign oBusy      = state_q != IDLE;
  assign oDone      = done_q;
  assign oDivByZero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_16b.sv
// tb_restoring_divider_16b: directed vector table plus handshake corner cases for the divider
module tb_restoring_divider_16b;
  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iStart = 1'b0;
  logic [15:0] iDividend = '0;
  logic [15:0] iDivisor = '0;
  logic [15:0] oQuotient, oRemainder;
  logic        oBusy, oDone, oDivByZero;
  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_done = 0;

  restoring_divider_16b #(.WIDTH(16)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iDividend(iDividend), .iDivisor(iDivisor),
    .oQuotient(oQuotient), .oRemainder(oRemainder),
    .oBusy(oBusy), .oDone(oDone), .oDivByZero(oDivByZero)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) if (oDone) n_done++;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    iDividend = a;
    iDivisor  = b;
    iStart    = 1'b1;
    @(posedge iClk);
    #1;
    iStart    = 1'b0;
    iDividend = 16'(($urandom));
    iDivisor  = 16'($urandom);
    n_start++;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!oDone && lat < 40) begin
      @(posedge iClk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string name, input vec_t v);
    int lat;
    launch(v.a, v.b);
    if (v.b != 0) chk({name, " busy"}, 32'(oBusy), 32'd1);
    wait_done(lat);
    chk({name, " latency"}, 32'(lat), (v.b == 0) ? 32'd1 : 32'd17);
    chk({name, " quotient"}, 32'(oQuotient), 32'(v.q));
    chk({name, " remainder"}, 32'(oRemainder), 32'(v.r));
    chk({name, " divbyzero"}, 32'(oDivByZero), 32'(v.z));
    chk({name, " busy at done"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    vec_t tbl[10];
    int   lat;
    int   snap;
    tbl[0] = '{16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0};
    tbl[1] = '{16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1};
    tbl[2] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{16'd12345, 16'd123, 16'd100, 16'd45, 1'b0};
    tbl[4] = '{16'd100, 16'd200, 16'd0, 16'd100, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h0100, 16'h007F, 16'h00FF, 1'b0};
`ifdef DIVIDER_SIGNED_EN
    tbl[8] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
    tbl[9] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
`else
    tbl[8] = '{16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0};
    tbl[9] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 1'b0};
`endif
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b0;
    chk("reset quotient", 32'(oQuotient), 32'd0);
    chk("reset remainder", 32'(oRemainder), 32'd0);
    chk("reset busy", 32'(oBusy), 32'd0);
    chk("reset done", 32'(oDone), 32'd0);
    chk("reset divbyzero", 32'(oDivByZero), 32'd0);

    for (int i = 0; i < 10; i++) run($sformatf("vec%0d", i), tbl[i]);

    // back-to-back: second start issued in the first done cycle
    launch(16'hFFFF, 16'h0001);
    wait_done(lat);
    chk("b2b first quotient", 32'(oQuotient), 32'hFFFF);
    chk("b2b first remainder", 32'(oRemainder), 32'h0000);
    launch(16'd3, 16'd10);
    chk("b2b done pulse width", 32'(oDone), 32'd0);
    chk("b2b second busy", 32'(oBusy), 32'd1);
    wait_done(lat);
    chk("b2b spacing", 32'(lat + 1), 32'd18);
    chk("b2b second quotient", 32'(oQuotient), 32'h0000);
    chk("b2b second remainder", 32'(oRemainder), 32'h0003);

    // start while busy is ignored
    launch(16'h03E8, 16'h0007);
    repeat (4) @(posedge iClk);
    #1;
    iDividend = 16'd9;
    iDivisor  = 16'd3;
    iStart    = 1'b1;
    @(posedge iClk);
    #1;
    iStart    = 1'b0;
    wait_done(lat);
    chk("busy-ignore latency", 32'(lat + 5), 32'd17);
    chk("busy-ignore quotient", 32'(oQuotient), 32'h008E);
    chk("busy-ignore remainder", 32'(oRemainder), 32'h0006);
    @(posedge iClk);
    #1;
    chk("busy-ignore no second run", 32'(oBusy), 32'd0);

    // reset mid-run aborts with no done, start alongside reset ignored
    launch(16'd9, 16'd3);
    n_start--;
    repeat (7) @(posedge iClk);
    #1;
    iRst   = 1'b1;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iRst   = 1'b0;
    iStart = 1'b0;
    snap   = n_done;
    chk("abort quotient", 32'(oQuotient), 32'd0);
    chk("abort remainder", 32'(oRemainder), 32'd0);
    chk("abort busy", 32'(oBusy), 32'd0);
    chk("abort done", 32'(oDone), 32'd0);
    chk("abort divbyzero", 32'(oDivByZero), 32'd0);
    repeat (25) @(posedge iClk);
    #1;
    chk("abort no done", 32'(n_done), 32'(snap));

    // random positive operands, valid in both unsigned and signed builds
    for (int i = 0; i < 1000; i++) begin
      vec_t v;
      v.a = 16'($urandom_range(0, 32767));
      v.b = 16'($urandom_range(1, 32767));
      if (i % 4 == 0) v.b = 16'($urandom_range(1, 255));
      v.q = v.a / v.b;
      v.r = v.a % v.b;
      v.z = 1'b0;
      run($sformatf("rnd%0d", i), v);
    end

    repeat (3) @(posedge iClk);
    #1;
    chk("done count", 32'(n_done), 32'(n_start));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
